// File: rtl/uart_host_rx_fifo.sv
// uart_host_rx_fifo
//   Host-side 8N1 UART receiver with a first-word-fall-through byte FIFO
//   and hardware flow control toward the sending SoC.
// Ports:
//   clk          system clock
//   cpu_resetn   asynchronous active-low reset
//   rxd          serial input, idle high, asynchronous to clk
//   out_data     head-of-FIFO byte (registered)
//   out_valid    out_data valid (registered)
//   out_ready    consumer accepts the head byte when out_valid && out_ready
//   cts_n        0 = sender may transmit, 1 = hold off (registered)
//   fill         current FIFO occupancy
//   frame_err    1-cycle pulse: stop bit sampled low
//   overflow_err 1-cycle pulse: received byte dropped because FIFO full
module uart_host_rx_fifo #(
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned BAUD          = 3000000,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned CTS_THRESHOLD = 12
) (
    input  logic                          clk,
    input  logic                          cpu_resetn,
    input  logic                          rxd,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          cts_n,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          frame_err,
    output logic                          overflow_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      FULL_LVL    = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      CTS_LVL     = (AW+1)'(CTS_THRESHOLD);

    if (CLKS_PER_BIT < 4) begin : g_baud_chk
        $error("CLK_FREQ/BAUD must be at least 4");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (CTS_THRESHOLD < 1 || CTS_THRESHOLD > FIFO_DEPTH) begin : g_cts_chk
        $error("CTS_THRESHOLD must be in 1..FIFO_DEPTH");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

    // ---------------- receiver ----------------
    logic             rx_meta_q, rx_s_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push, frame_err_d;
    logic             frame_err_q;

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rxd;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = BIT_RELOAD;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    cnt_d   = BIT_RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end
            end
            S_BREAK: begin
                // Held-low line: stay here until it idles so a break reports once.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, fill_w;
    logic        full, pop, push_ok;
    logic [7:0]  out_data_q, head_d;
    logic        out_valid_q, cts_n_q, overflow_err_q;

    assign fill_w  = wr_q - rd_q;
    assign full    = (fill_w == FULL_LVL);
    assign pop     = out_valid_q & out_ready;
    assign push_ok = push & (~full | pop);
    assign wr_d    = wr_q + (AW+1)'(push_ok);
    assign rd_d    = rd_q + (AW+1)'(pop);

    // Output register tracks the next head; a byte written into an empty
    // FIFO is forwarded directly because the memory is not yet updated.
    always_comb begin
        head_d = mem_q[rd_d[AW-1:0]];
        if (push_ok && (rd_d == wr_q)) begin
            head_d = shreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_q           <= '0;
            rd_q           <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            cts_n_q        <= 1'b1;
            overflow_err_q <= 1'b0;
        end else begin
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            out_data_q     <= head_d;
            out_valid_q    <= (wr_d != rd_d);
            cts_n_q        <= (fill_w >= CTS_LVL);
            overflow_err_q <= push & full & ~pop;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign cts_n        = cts_n_q;
    assign fill         = fill_w;
    assign frame_err    = frame_err_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_uart_host_rx_fifo.sv
module tb_uart_host_rx_fifo;

    logic       clk = 1'b0;
    logic       cpu_resetn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       cts_n;
    logic [4:0] fill;
    logic       frame_err;
    logic       overflow_err;

    uart_host_rx_fifo #(
        .CLK_FREQ(100000000),
        .BAUD(10000000),
        .FIFO_DEPTH(16),
        .CTS_THRESHOLD(12)
    ) dut (
        .clk(clk),
        .cpu_resetn(cpu_resetn),
        .rxd(rxd),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cts_n(cts_n),
        .fill(fill),
        .frame_err(frame_err),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: samples 1ns after the falling edge, i.e. with the inputs for
    // the coming rising edge already applied.
    logic [7:0] rxq[$];
    int         fe_cnt = 0;
    int         of_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        #1;
        if (!cpu_resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("out_data_hold", out_data, prev_data);
            if (out_valid && out_ready) rxq.push_back(out_data);
            if (frame_err) fe_cnt++;
            if (overflow_err) of_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // 10 clk per bit; leaves the line at the stop-bit level.
    task automatic send_bits(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (10) @(negedge clk);
        end
        rxd = stop;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(d, 1'b1);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic clear_mon();
        rxq.delete();
        fe_cnt = 0;
        of_cnt = 0;
    endtask

    task automatic expect_queue(input string nm, input logic [7:0] base, input int n);
        check({nm, "_count"}, rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++)
            check({nm, "_data"}, rxq[i], base + 8'(i));
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_beats;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{d: 8'hA5, stop: 1'b1, exp_beats: 1, exp_fe: 0};
        vecs[1] = '{d: 8'h00, stop: 1'b1, exp_beats: 1, exp_fe: 0};
        vecs[2] = '{d: 8'hFF, stop: 1'b1, exp_beats: 1, exp_fe: 0};
        vecs[3] = '{d: 8'h81, stop: 1'b1, exp_beats: 1, exp_fe: 0};
        vecs[4] = '{d: 8'h55, stop: 1'b0, exp_beats: 0, exp_fe: 1};
        vecs[5] = '{d: 8'h3C, stop: 1'b1, exp_beats: 1, exp_fe: 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fill", fill, 0);
        check("rst_cts_n", cts_n, 1);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow_err", overflow_err, 0);
        cpu_resetn = 1'b1;
        @(negedge clk);
        check("cts_after_release", cts_n, 0);
        repeat (5) @(negedge clk);

        // Single frames, consumer always ready
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            clear_mon();
            send_bits(vecs[k].d, vecs[k].stop);
            rxd = 1'b1;
            repeat (15) @(negedge clk);
            check("vec_beats", rxq.size(), vecs[k].exp_beats);
            if (vecs[k].exp_beats == 1 && rxq.size() == 1) check("vec_data", rxq[0], vecs[k].d);
            check("vec_frame_err", fe_cnt, vecs[k].exp_fe);
            check("vec_overflow", of_cnt, 0);
            check("vec_fill", fill, 0);
            check("vec_cts_n", cts_n, 0);
        end

        // CTS threshold
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(8'(i));
        check("cts_fill11", fill, 11);
        check("cts_low_at11", cts_n, 0);
        fork
            send_byte(8'h0B);
            begin
                int n = 0;
                @(negedge clk);
                while (fill != 12 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("cts_fill12_seen", fill, 12);
                check("cts_lag_cycle", cts_n, 0);
                @(negedge clk);
                check("cts_high_at12", cts_n, 1);
            end
        join
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        expect_queue("cts_drain", 8'h00, 12);
        check("cts_drained_fill", fill, 0);
        check("cts_drained_cts", cts_n, 0);

        // Overflow
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
        check("ovf_fill", fill, 16);
        check("ovf_pulses", of_cnt, 1);
        check("ovf_cts", cts_n, 1);
        out_ready = 1'b1;
        repeat (25) @(negedge clk);
        expect_queue("ovf_drain", 8'h10, 16);
        check("ovf_fill_empty", fill, 0);

        // Framing error with held-low line, then a clean byte
        clear_mon();
        send_bits(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h3C);
        repeat (10) @(negedge clk);
        check("brk_frame_err", fe_cnt, 1);
        expect_queue("brk_out", 8'h3C, 1);

        // Short glitch on idle line
        clear_mon();
        @(negedge clk);
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_beats", rxq.size(), 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_fill", fill, 0);
        send_byte(8'h96);
        repeat (10) @(negedge clk);
        expect_queue("glitch_next", 8'h96, 1);

        // Full FIFO: push and pop in the same cycle
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
        check("fullpp_fill_before", fill, 16);
        fork
            send_byte(8'h50);
            begin
                // push lands on the 98th rising edge after the start-bit edge
                @(negedge clk);
                repeat (97) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("fullpp_fill", fill, 16);
                check("fullpp_no_ovf", overflow_err, 0);
            end
        join
        check("fullpp_ovf_cnt", of_cnt, 0);
        out_ready = 1'b1;
        repeat (25) @(negedge clk);
        expect_queue("fullpp_drain", 8'h40, 17);

        // Reset mid-frame with bytes buffered
        clear_mon();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
        check("mrst_fill_before", fill, 5);
        fork
            send_byte(8'hAA);
            begin
                @(negedge clk);
                repeat (40) @(negedge clk);
                cpu_resetn = 1'b0;
                @(negedge clk);
                check("mrst_valid", out_valid, 0);
                check("mrst_fill", fill, 0);
                check("mrst_cts", cts_n, 1);
                check("mrst_data", out_data, 0);
            end
        join
        repeat (3) @(negedge clk);
        cpu_resetn = 1'b1;
        @(negedge clk);
        check("mrst_cts_release", cts_n, 0);
        check("mrst_fill_release", fill, 0);
        clear_mon();
        out_ready = 1'b1;
        send_byte(8'h7E);
        repeat (10) @(negedge clk);
        expect_queue("mrst_next", 8'h7E, 1);
        check("mrst_fe", fe_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
